// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 5-stage RV32 pipeline.
// Accepts one instruction per handshake from EX. For loads it waits for the
// read-data response, then extracts the byte/half/word and extends it. It
// hands {wen, waddr, result, PC} to WB and drives a forwarding/hazard bus to ID.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   EX_to_MEM_Valid / _Bus           instruction from EX
//                                    [73] wen [72:68] waddr [67] is_load
//                                    [66:64] funct3 [63:32] alu_result [31:0] PC
//   MEM_Allow_in                     MEM can take an instruction this cycle
//   WB_Allow_in                      WB can take an instruction this cycle
//   MEM_to_WB_Valid / _Bus           [69] wen [68:64] waddr [63:32] result [31:0] PC
//   Read_data / _Valid / _Ready      load response handshake (full aligned word)
//   rdw_MEM_Bus                      [38] valid [37] rf_wen [36:32] waddr [31:0] data
//   MEM_load_busy                    load in MEM without data yet (ID must stall)
module mem_stage #(
    parameter int unsigned EX_TO_MEM_BUS_WD = 74,
    parameter int unsigned MEM_TO_WB_BUS_WD = 70,
    parameter int unsigned RDW_BUS_WD       = 39
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        EX_to_MEM_Valid,
    input  logic [EX_TO_MEM_BUS_WD-1:0] EX_to_MEM_Bus,
    output logic                        MEM_Allow_in,
    input  logic                        WB_Allow_in,
    output logic                        MEM_to_WB_Valid,
    output logic [MEM_TO_WB_BUS_WD-1:0] MEM_to_WB_Bus,
    input  logic [31:0]                 Read_data,
    input  logic                        Read_data_Valid,
    output logic                        Read_data_Ready,
    output logic [RDW_BUS_WD-1:0]       rdw_MEM_Bus,
    output logic                        MEM_load_busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned ISLOAD_BIT = 67;

    logic [1:0]                  state_q;
    logic [1:0]                  state_d;
    logic                        mem_valid;
    logic [EX_TO_MEM_BUS_WD-1:0] bus_r;
    logic [31:0]                 ld_word;

    logic        wen;
    logic [4:0]  waddr;
    logic        is_load;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic        mem_ready;
    logic        accept;
    logic        accept_load;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic [31:0] final_result;

    // Field decode of the held instruction
    assign wen        = bus_r[73];
    assign waddr      = bus_r[72:68];
    assign is_load    = bus_r[ISLOAD_BIT];
    assign funct3     = bus_r[66:64];
    assign alu_result = bus_r[63:32];
    assign pc         = bus_r[31:0];

    // Pipeline handshake
    assign mem_ready       = !is_load || (state_q == ST_DONE);
    assign MEM_Allow_in    = !mem_valid || (mem_ready && WB_Allow_in);
    assign MEM_to_WB_Valid = mem_valid && mem_ready;
    assign accept          = EX_to_MEM_Valid && MEM_Allow_in;
    assign accept_load     = accept && EX_to_MEM_Bus[ISLOAD_BIT];

    // The FSM only leaves IDLE for a load, so WAIT implies a valid load in MEM
    assign Read_data_Ready = (state_q == ST_WAIT);
    assign MEM_load_busy   = mem_valid && is_load && (state_q != ST_DONE);

    // Valid bit
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid <= 1'b0;
        end else if (MEM_Allow_in) begin
            mem_valid <= EX_to_MEM_Valid;
        end
    end

    // Instruction register (not reset)
    always_ff @(posedge clk) begin
        if (accept) begin
            bus_r <= EX_to_MEM_Bus;
        end
    end

    // Load data capture; held stable through DONE
    always_ff @(posedge clk) begin
        if ((state_q == ST_WAIT) && Read_data_Valid) begin
            ld_word <= Read_data;
        end
    end

    // Load FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Load FSM next state; a load accepted during DONE's handoff goes straight to WAIT
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_load) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (Read_data_Valid) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (WB_Allow_in) begin
                    state_d = accept_load ? ST_WAIT : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Load extraction by byte offset and funct3
    always_comb begin
        ld_byte = 8'h00;
        ld_half = alu_result[1] ? ld_word[31:16] : ld_word[15:0];
        ld_val  = ld_word;
        case (alu_result[1:0])
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        case (funct3)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_val = {24'h000000, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_val = {16'h0000, ld_half};
            default: ld_val = ld_word;
        endcase
    end

    assign final_result = is_load ? ld_val : alu_result;

    assign MEM_to_WB_Bus = {wen, waddr, final_result, pc};

    // Forwarding bus; data is meaningless while MEM_load_busy is high
    assign rdw_MEM_Bus = {mem_valid, mem_valid && wen, waddr, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios with literal
// expectations followed by randomized traffic checked against a slot model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [73:0] ex_bus;
    logic        allow_in;
    logic        wb_allow;
    logic        wbv;
    logic [69:0] wb_bus;
    logic [31:0] rd;
    logic        rdv;
    logic        rdr;
    logic [38:0] rdw;
    logic        busy;

    int errors = 0;
    int checks = 0;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .EX_to_MEM_Valid (ex_valid),
        .EX_to_MEM_Bus   (ex_bus),
        .MEM_Allow_in    (allow_in),
        .WB_Allow_in     (wb_allow),
        .MEM_to_WB_Valid (wbv),
        .MEM_to_WB_Bus   (wb_bus),
        .Read_data       (rd),
        .Read_data_Valid (rdv),
        .Read_data_Ready (rdr),
        .rdw_MEM_Bus     (rdw),
        .MEM_load_busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [73:0] mk(input logic wen, input logic [4:0] wa, input logic ld,
                                       input logic [2:0] f3, input logic [31:0] alu,
                                       input logic [31:0] pcv);
        return {wen, wa, ld, f3, alu, pcv};
    endfunction

    // What the instruction must produce, from the ISA load rules
    function automatic logic [31:0] expect_result(input logic [73:0] b, input logic [31:0] w);
        longint v;
        int unsigned a;
        a = {30'd0, b[33:32]};
        if (!b[67]) return b[63:32];
        case (b[66:64])
            3'b000: begin
                v = longint'((w >> (8 * a)) & 32'hFF);
                if (v >= 128) v = v - 256;
                return 32'(v);
            end
            3'b100: return (w >> (8 * a)) & 32'hFF;
            3'b001: begin
                v = longint'((w >> (16 * (a / 2))) & 32'hFFFF);
                if (v >= 32768) v = v - 65536;
                return 32'(v);
            end
            3'b101: return (w >> (16 * (a / 2))) & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    // Slot model: one instruction, plus whether its load data has arrived
    logic        m_ok = 1'b0;
    logic        m_valid;
    logic        m_have;
    logic [73:0] m_bus;
    logic [31:0] m_word;
    logic        m_ld;
    logic        m_rdy;
    logic        m_allow;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b0;
            m_have  = 1'b0;
            m_ok    = 1'b1;
        end else if (m_ok) begin
            m_ld    = m_valid && m_bus[67];
            m_rdy   = !m_bus[67] || m_have;
            m_allow = !m_valid || (m_rdy && wb_allow);
            if (m_ld && !m_have && rdv) begin
                m_have = 1'b1;
                m_word = rd;
            end
            if (m_allow) begin
                m_valid = ex_valid;
                m_have  = 1'b0;
                if (ex_valid) m_bus = ex_bus;
            end
        end
    end

    logic        e_rdy;
    logic        e_wbv;
    logic        e_wait;
    logic [31:0] e_res;

    always @(negedge clk) begin
        if (m_ok) begin
            e_rdy  = !m_bus[67] || m_have;
            e_wbv  = m_valid && e_rdy;
            e_wait = m_valid && m_bus[67] && !m_have;
            chk("m_wb_valid", 74'(wbv), 74'(e_wbv));
            chk("m_allow_in", 74'(allow_in), 74'(!m_valid || (e_rdy && wb_allow)));
            chk("m_rd_ready", 74'(rdr), 74'(e_wait));
            chk("m_load_busy", 74'(busy), 74'(e_wait));
            chk("m_rdw_valid", 74'(rdw[38]), 74'(m_valid));
            chk("m_rdw_wen", 74'(rdw[37]), 74'(m_valid && m_bus[73]));
            if (m_valid && !e_wait) begin
                e_res = expect_result(m_bus, m_word);
                chk("m_rdw_data", 74'(rdw[36:0]), 74'({m_bus[72:68], e_res}));
            end
            if (e_wbv) begin
                chk("m_wb_bus", 74'(wb_bus), 74'({m_bus[73:68], e_res, m_bus[31:0]}));
            end
        end
    end

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_bus = '0; wb_allow = 1'b1; rdv = 1'b0; rd = '0;

        // Reset
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wb_valid", 74'(wbv), 74'(0));
        chk("rst_rd_ready", 74'(rdr), 74'(0));
        chk("rst_allow_in", 74'(allow_in), 74'(1));
        chk("rst_rdw_valid", 74'(rdw[38]), 74'(0));

        // Non-load stream at one per cycle
        tick();
        ex_valid = 1'b1;
        ex_bus   = mk(1'b1, 5'd5, 1'b0, 3'b000, 32'h11, 32'h100);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i < 2) ex_bus = mk(1'b1, 5'd5, 1'b0, 3'b000, 32'(8'h11 * (i + 2)), 32'(32'h100 + 4 * (i + 1)));
            else       ex_valid = 1'b0;
            @(negedge clk);
            chk("alu_wb_valid", 74'(wbv), 74'(1));
            chk("alu_result", 74'(wb_bus[63:32]), 74'(8'h11 * (i + 1)));
            chk("alu_pc", 74'(wb_bus[31:0]), 74'(32'h100 + 4 * i));
            chk("alu_allow_in", 74'(allow_in), 74'(1));
        end

        // lb with late response
        tick();
        ex_valid = 1'b1;
        ex_bus   = mk(1'b1, 5'd7, 1'b1, 3'b000, 32'h1003, 32'h200);
        tick();
        ex_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lb_busy", 74'(busy), 74'(1));
            chk("lb_allow_in", 74'(allow_in), 74'(0));
            chk("lb_wb_valid", 74'(wbv), 74'(0));
            tick();
        end
        rdv = 1'b1; rd = 32'h80FF7F01;
        tick();
        rdv = 1'b0;
        @(negedge clk);
        chk("lb_wb_valid_done", 74'(wbv), 74'(1));
        chk("lb_result", 74'(wb_bus[63:32]), 74'(32'hFFFFFF80));

        // lhu
        tick();
        ex_valid = 1'b1;
        ex_bus   = mk(1'b1, 5'd9, 1'b1, 3'b101, 32'h1002, 32'h204);
        tick();
        ex_valid = 1'b0; rdv = 1'b1; rd = 32'h8001ABCD;
        tick();
        rdv = 1'b0;
        @(negedge clk);
        chk("lhu_wb_valid", 74'(wbv), 74'(1));
        chk("lhu_result", 74'(wb_bus[63:32]), 74'(32'h00008001));

        // lw held under WB backpressure, then handoff with a new load accepted
        tick();
        ex_valid = 1'b1;
        ex_bus   = mk(1'b1, 5'd10, 1'b1, 3'b010, 32'h2000, 32'h208);
        tick();
        ex_valid = 1'b0; rdv = 1'b1; rd = 32'hDEADBEEF; wb_allow = 1'b0;
        tick();
        rdv = 1'b0; rd = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_wb_valid", 74'(wbv), 74'(1));
            chk("bp_result", 74'(wb_bus[63:32]), 74'(32'hDEADBEEF));
            chk("bp_allow_in", 74'(allow_in), 74'(0));
            tick();
        end
        wb_allow = 1'b1; ex_valid = 1'b1;
        ex_bus   = mk(1'b1, 5'd11, 1'b1, 3'b000, 32'h3001, 32'h20C);
        @(negedge clk);
        chk("bp_handoff_allow", 74'(allow_in), 74'(1));
        tick();
        ex_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_wait_ready", 74'(rdr), 74'(1));
        chk("bp_next_busy", 74'(busy), 74'(1));
        chk("bp_next_wb_valid", 74'(wbv), 74'(0));

        // Reset while waiting, then a late response
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rml_rd_ready", 74'(rdr), 74'(0));
        chk("rml_rdw_valid", 74'(rdw[38]), 74'(0));
        chk("rml_busy", 74'(busy), 74'(0));
        tick();
        rdv = 1'b1; rd = 32'h12345678;
        @(negedge clk);
        chk("rml_late_rd_ready", 74'(rdr), 74'(0));
        tick();
        rdv = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rml_no_wb_valid", 74'(wbv), 74'(0));
            chk("rml_no_valid", 74'(rdw[38]), 74'(0));
            tick();
        end

        // Randomized traffic against the slot model
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 199) == 0);
            ex_valid = ($urandom_range(0, 99) < 70);
            ex_bus   = mk(1'($urandom), 5'($urandom), ($urandom_range(0, 2) == 0),
                          3'($urandom), $urandom, $urandom);
            wb_allow = ($urandom_range(0, 99) < 75);
            rdv      = ($urandom_range(0, 99) < 40);
            rd       = $urandom;
            tick();
        end
        rst = 1'b0; ex_valid = 1'b0; wb_allow = 1'b1; rdv = 1'b1;
        repeat (5) tick();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
